button_debouncer: RTL and testbench

Debounces an asynchronous mechanical push-button input and produces a clean level plus a single-cycle `pulse` per accepted press. `pulse` drives the `en` input of the 4-bit synchronous up-counter, so each physical press advances the count by exactly one. Sits between the board pin and the counter, in the counter's `clk` domain.

---
 rtl/button_debouncer_pkg.sv | 20 ++
 rtl/button_debouncer_sync_chain.sv | 29 ++
 rtl/button_debouncer.sv | 136 +++++++++++++
 tb/tb_button_debouncer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared FSM encoding and counter width helpers for the push-button debouncer.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } db_state_e;

    // Bits needed to hold a count of 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// SYNC_STAGES-deep flip-flop synchronizer for one asynchronous bit; latency STAGES edges.
// No flow control: samples every clk edge, async active-high reset clears the chain to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: clean level plus one-cycle pulse per press, SYNC_STAGES+DEBOUNCE_CYCLES edges latency.
// No backpressure; optional auto-repeat pulses enabled by defining BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic pulse
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("button_debouncer: SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
    end

    logic             btn_s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             rpt_fire;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_in),
        .dout (btn_s)
    );

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int               RPT_W       = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_armed_q, rpt_armed_d;

    // Counter only runs while held in PRESSED; any exit drops it back to 0 and
    // re-arms the long initial delay.
    always_comb begin
        rpt_d       = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        if (state_q == PRESSED && btn_s) begin
            if (rpt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_d       = rpt_q + RPT_W'(1);
                rpt_armed_d = rpt_armed_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        pulse_d = rpt_fire;
        // Stability count tracks how long btn_s has disagreed with the accepted level.
        cnt_d   = (btn_s == level_q) ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            RELEASED: begin
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!btn_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RELEASED;
                level_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn_level = level_q;
    assign pulse     = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, hand-written corner sequences, random stimulus vs reference model.
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int LAT  = SYNC + DB;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic pulse;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .pulse     (pulse)
    );

    // Downstream 4-bit counter enabled by pulse.
    logic [3:0] q_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_cnt <= 4'd0;
        else if (pulse) q_cnt <= q_cnt + 4'd1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: btn_s is btn_in delayed SYNC edges; the level flips once
    // btn_s has disagreed with it for DB consecutive edges; t counts edges spent
    // held in the settled-pressed condition for repeat pulses.
    bit mq[$];
    bit m_level, m_pulse;
    int m_run, m_t;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_run   = 0;
        m_t     = 0;
    endtask

    task automatic model_edge(input bit b_in);
        bit b, was_pressed, np;
        b = mq.pop_front();
        mq.push_back(b_in);
        was_pressed = m_level && (m_run == 0);
        np = 1'b0;
        if (b != m_level) m_run++;
        else m_run = 0;
        if (m_run == DB) begin
            m_level = b;
            m_run   = 0;
            m_t     = 0;
            np      = b;
        end else if (AR && was_pressed && b) begin
            m_t++;
            if (m_t >= RD && ((m_t - RD) % RP) == 0) np = 1'b1;
        end else begin
            m_t = 0;
        end
        m_pulse = np;
    endtask

    int edge_i;
    int pulse_edges[$];
    int level_edges[$];
    logic lvl_prev;

    task automatic begin_seg();
        edge_i = 0;
        pulse_edges.delete();
        level_edges.delete();
        lvl_prev = btn_level;
    endtask

    task automatic step(input bit b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        edge_i++;
        if (pulse) pulse_edges.push_back(edge_i);
        if (btn_level != lvl_prev) level_edges.push_back(edge_i);
        lvl_prev = btn_level;
        chk("model_pulse", int'(pulse), int'(m_pulse));
        chk("model_level", int'(btn_level), int'(m_level));
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Called at a falling edge; asserts reset away from the active edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_level", int'(btn_level), 0);
        chk("reset_pulse", int'(pulse), 0);
        chk("reset_count", int'(q_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    typedef struct {
        bit btn;
        int cycles;
        int exp_pulses;
        bit exp_level;
    } vec_t;

    vec_t tbl[$];
    int   exp_edges[$];
    int   bounce_pulses;
    bit   rb;
    int   len;

    initial begin
        model_reset();
        btn_in = 1'b0;
        rst    = 1'b1;
        #1;
        chk("por_level", int'(btn_level), 0);
        chk("por_pulse", int'(pulse), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: each record holds btn_in for a number of cycles.
        tbl.push_back('{1'b0,  5, 0, 1'b0});
        tbl.push_back('{1'b1, 25, 1, 1'b1});             // clean press
        tbl.push_back('{1'b0, 20, 0, 1'b0});             // clean release
        tbl.push_back('{1'b1,  5, 0, 1'b0});             // glitch too short
        tbl.push_back('{1'b0, 20, 0, 1'b0});
        tbl.push_back('{1'b1, 12, 1, 1'b1});
        tbl.push_back('{1'b0,  3, 0, 1'b1});             // release reversal
        tbl.push_back('{1'b1, 25, AR ? 1 : 0, 1'b1});    // back to pressed, full repeat delay
        tbl.push_back('{1'b0, 20, 0, 1'b0});
        foreach (tbl[i]) begin
            begin_seg();
            hold(tbl[i].btn, tbl[i].cycles);
            chk($sformatf("vec%0d_pulses", i), pulse_edges.size(), tbl[i].exp_pulses);
            chk($sformatf("vec%0d_level", i), int'(btn_level), int'(tbl[i].exp_level));
        end

        // Clean press from reset: pulse exactly LAT edges after first high sample.
        @(negedge clk);
        do_reset();
        begin_seg();
        hold(1'b1, 25);
        chk("clean_pulse_edge", first_of(pulse_edges), LAT);
        chk("clean_pulse_count", pulse_edges.size(), 1);
        chk("clean_level_edge", first_of(level_edges), LAT);
        chk("clean_counter_q", int'(q_cnt), 1);

        // Release bounce: toggles every 4 cycles keep the level high.
        bounce_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            begin_seg();
            hold(k[0], 4);
            bounce_pulses += pulse_edges.size();
            chk("relbounce_level", int'(btn_level), 1);
        end
        chk("relbounce_pulses", bounce_pulses, 0);
        begin_seg();
        hold(1'b0, 20);
        chk("release_level_edge", first_of(level_edges), LAT);
        chk("release_pulses", pulse_edges.size(), 0);

        // Bouncy press: toggles every 3 cycles, then stays high.
        bounce_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            begin_seg();
            hold(~k[0], 3);
            bounce_pulses += pulse_edges.size();
        end
        chk("bounce_no_pulse", bounce_pulses, 0);
        begin_seg();
        hold(1'b1, 25);
        chk("bounce_pulse_edge", first_of(pulse_edges), LAT);
        chk("bounce_pulse_count", pulse_edges.size(), 1);

        // Reset while pressed forces level low immediately.
        chk("pre_reset_level", int'(btn_level), 1);
        do_reset();
        begin_seg();
        hold(1'b0, 20);

        // Reset 4 cycles into the stability count; button still held afterwards.
        begin_seg();
        hold(1'b1, 2 + 4);
        chk("pw_no_pulse", pulse_edges.size(), 0);
        do_reset();
        begin_seg();
        hold(1'b1, 20);
        chk("pw_reset_pulse_edge", first_of(pulse_edges), LAT);
        chk("pw_reset_pulse_count", pulse_edges.size(), 1);
        hold(1'b0, 20);

        // Long hold: auto-repeat schedule (single pulse when disabled).
        do_reset();
        begin_seg();
        hold(1'b1, LAT + 39);
        exp_edges.delete();
        exp_edges.push_back(LAT);
        if (AR) begin
            for (int e = LAT + RD; e <= LAT + 39; e += RP) exp_edges.push_back(e);
        end
        chk("hold_pulse_count", pulse_edges.size(), exp_edges.size());
        for (int k = 0; k < exp_edges.size() && k < pulse_edges.size(); k++)
            chk($sformatf("hold_pulse%0d_edge", k), pulse_edges[k], exp_edges[k]);
        chk("hold_counter_q", int'(q_cnt), exp_edges.size());
        hold(1'b0, 20);

        // Random segments against the model, with occasional async resets.
        for (int s = 0; s < 300; s++) begin
            rb  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
            begin_seg();
            hold(rb, len);
            if ($urandom_range(0, 24) == 0) do_reset();
        end
        hold(1'b0, 20);
        chk("final_level", int'(btn_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
